// File: rtl/bin_bcd_seq_if.sv
// Handshake and result bundle between the binary source, the BCD converter
// and the seven-segment digit decoders.
interface bin_bcd_seq_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic [WIDTH-1:0]    BIN_IN;
   logic                START;
   logic                BUSY;
   logic                DONE;
   logic [4*DIGITS-1:0] DEC_OUT;
   logic [DIGITS-1:0]   LZ_MASK;

   modport master (
      output BIN_IN, START,
      input  BUSY, DONE, DEC_OUT, LZ_MASK
   );

   modport slave (
      input  BIN_IN, START,
      output BUSY, DONE, DEC_OUT, LZ_MASK
   );
endinterface

// File: rtl/bin_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Results and leading-zero mask are held stable between DONE pulses.
module bin_bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic         CLK,
   input  logic         RESET_N,
   bin_bcd_seq_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [DIGITS-1:0] LZ_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   typedef enum logic {IDLE, CONV} state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    bin_sr_q, bin_sr_d;
   logic [4*DIGITS-1:0] bcd_sr_q, bcd_sr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [4*DIGITS-1:0] dec_q, dec_d;
   logic [DIGITS-1:0]   lz_q, lz_d;
   logic                done_q, done_d;
   logic [4*DIGITS-1:0] bcd_adj;
   logic [4*DIGITS-1:0] bcd_next;

   // Each nibble is corrected independently; no carry crosses digit borders.
   function automatic logic [4*DIGITS-1:0] add3_digits(input logic [4*DIGITS-1:0] v);
      logic [4*DIGITS-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // Units digit is never blanked so that a value of zero still shows "0".
   function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [4*DIGITS-1:0] d);
      logic [DIGITS-1:0] r;
      logic              all_zero;
      r        = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero && (d[4*i +: 4] == 4'd0);
         r[i]     = all_zero;
      end
      return r;
   endfunction

   always_comb begin
      bcd_adj  = add3_digits(bcd_sr_q);
      bcd_next = (bcd_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_sr_q[WIDTH-1]};

      state_d  = state_q;
      bin_sr_d = bin_sr_q;
      bcd_sr_d = bcd_sr_q;
      cnt_d    = cnt_q;
      dec_d    = dec_q;
      lz_d     = lz_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.START) begin
               bin_sr_d = bus.BIN_IN;
               bcd_sr_d = '0;
               cnt_d    = '0;
               state_d  = CONV;
            end
         end
         CONV: begin
            bin_sr_d = bin_sr_q << 1;
            bcd_sr_d = bcd_next;
            cnt_d    = cnt_q + CNT_W'(1);
            // Final shift: publish the completed digits in the same edge.
            if (cnt_q == CNT_LAST) begin
               dec_d   = bcd_next;
               lz_d    = lead_zero_mask(bcd_next);
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         bin_sr_q <= '0;
         bcd_sr_q <= '0;
         cnt_q    <= '0;
         dec_q    <= '0;
         lz_q     <= LZ_RST;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bin_sr_q <= bin_sr_d;
         bcd_sr_q <= bcd_sr_d;
         cnt_q    <= cnt_d;
         dec_q    <= dec_d;
         lz_q     <= lz_d;
         done_q   <= done_d;
      end
   end

   assign bus.BUSY    = (state_q == CONV);
   assign bus.DONE    = done_q;
   assign bus.DEC_OUT = dec_q;
   assign bus.LZ_MASK = lz_q;
endmodule

// File: tb/tb_bin_bcd_seq.sv
// Bench for bin_bcd_seq: decimal-arithmetic reference model compared every
// cycle, plus directed scenarios with literal expected digits.
module tb_bin_bcd_seq;
   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;

   bin_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   bin_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Decimal digits straight from division by powers of ten.
   function automatic logic [19:0] bcd_of(input int v);
      logic [19:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Digit i (i>=1) is a leading zero exactly when v < 10^i.
   function automatic logic [4:0] lz_of(input int v);
      logic [4:0] r;
      int p;
      r = '0;
      p = 10;
      for (int i = 1; i < DIGITS; i++) begin
         r[i] = (v < p);
         p = p * 10;
      end
      return r;
   endfunction

   // Reference: a request is accepted when no conversion is outstanding and
   // its result appears WIDTH edges later.
   int          m_left = 0;
   logic [15:0] m_val  = '0;
   logic        m_done = 1'b0;
   logic [19:0] m_dec  = '0;
   logic [4:0]  m_lz   = 5'b11110;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_dec  <= '0;
         m_lz   <= 5'b11110;
      end else begin
         m_done <= 1'b0;
         if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_done <= 1'b1;
               m_dec  <= bcd_of(int'(m_val));
               m_lz   <= lz_of(int'(m_val));
            end
         end else if (bus.START) begin
            m_left <= WIDTH;
            m_val  <= bus.BIN_IN;
         end
      end
   end

   always @(negedge clk) begin
      check("busy", 32'(bus.BUSY), 32'(m_left != 0));
      check("done", 32'(bus.DONE), 32'(m_done));
      check("dec_out", 32'(bus.DEC_OUT), 32'(m_dec));
      check("lz_mask", 32'(bus.LZ_MASK), 32'(m_lz));
   end

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.DONE) ok = 1'b1;
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: got no DONE, expected DONE within 40 cycles");
      end
   endtask

   task automatic count_done(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.DONE) c++;
      end
   endtask

   // Called at posedge+2 while idle; returns at posedge+2 after DONE.
   task automatic convert(input logic [15:0] v, input logic [19:0] ed,
                          input logic [4:0] el, input bit noise);
      int a;
      bit ok;
      bus.START  = 1'b1;
      bus.BIN_IN = v;
      @(posedge clk); #2;
      a = cyc;
      bus.START  = 1'b0;
      bus.BIN_IN = 16'($urandom);
      if (noise) begin
         repeat ($urandom_range(1, 9)) begin @(posedge clk); #2; end
         bus.START  = 1'b1;
         bus.BIN_IN = 16'($urandom);
         @(posedge clk); #2;
         bus.START  = 1'b0;
      end
      wait_done(ok);
      if (ok) begin
         check("latency", 32'(cyc - a), 32'd16);
         check("result_dec", 32'(bus.DEC_OUT), 32'(ed));
         check("result_lz", 32'(bus.LZ_MASK), 32'(el));
      end
      @(posedge clk); #2;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1);
   end

   initial begin
      int          c;
      int          prev;
      bit          ok;
      logic [15:0] v;
      int          seq_v[4]  = '{9, 10, 99, 100};
      logic [19:0] seq_d[4]  = '{20'h00009, 20'h00010, 20'h00099, 20'h00100};
      logic [4:0]  seq_l[4]  = '{5'b11110, 5'b11100, 5'b11100, 5'b11000};

      bus.START  = 1'b0;
      bus.BIN_IN = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_busy", 32'(bus.BUSY), 32'd0);
      check("reset_done", 32'(bus.DONE), 32'd0);
      check("reset_dec", 32'(bus.DEC_OUT), 32'h00000);
      check("reset_lz", 32'(bus.LZ_MASK), 32'h1e);
      rst_n = 1'b1;
      @(posedge clk); #2;

      convert(16'd0,     20'h00000, 5'b11110, 1'b0);
      convert(16'd65535, 20'h65535, 5'b00000, 1'b0);
      convert(16'd1023,  20'h01023, 5'b10000, 1'b0);
      convert(16'd10000, 20'h10000, 5'b00000, 1'b0);

      // START during a conversion is dropped, not queued.
      bus.START  = 1'b1;
      bus.BIN_IN = 16'd42;
      @(posedge clk); #2;
      bus.START  = 1'b0;
      repeat (4) begin @(posedge clk); #2; end
      bus.START  = 1'b1;
      bus.BIN_IN = 16'd999;
      @(posedge clk); #2;
      bus.START  = 1'b0;
      wait_done(ok);
      if (ok) begin
         check("ignored_dec", 32'(bus.DEC_OUT), 32'h00042);
         check("ignored_lz", 32'(bus.LZ_MASK), 32'h1c);
      end
      @(posedge clk); #2;
      count_done(20, c);
      check("no_second_done", 32'(c), 32'd0);
      @(posedge clk); #2;

      // START held high: back-to-back conversions every WIDTH+1 cycles.
      bus.START  = 1'b1;
      bus.BIN_IN = 16'(seq_v[0]);
      @(posedge clk); #2;
      bus.BIN_IN = 16'(seq_v[1]);
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         wait_done(ok);
         if (ok) begin
            check("b2b_dec", 32'(bus.DEC_OUT), 32'(seq_d[i]));
            check("b2b_lz", 32'(bus.LZ_MASK), 32'(seq_l[i]));
            if (prev >= 0) check("b2b_period", 32'(cyc - prev), 32'd17);
            prev = cyc;
         end
         if (i < 3) begin
            @(posedge clk); #2;
            if (i + 2 < 4) bus.BIN_IN = 16'(seq_v[i + 2]);
            else           bus.START  = 1'b0;
         end
      end
      @(posedge clk); #2;

      // Asynchronous reset in the middle of a conversion.
      bus.START  = 1'b1;
      bus.BIN_IN = 16'd12345;
      @(posedge clk); #2;
      bus.START  = 1'b0;
      repeat (8) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.BUSY), 32'd0);
      check("abort_done", 32'(bus.DONE), 32'd0);
      check("abort_dec", 32'(bus.DEC_OUT), 32'h00000);
      check("abort_lz", 32'(bus.LZ_MASK), 32'h1e);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      count_done(20, c);
      check("abort_no_done", 32'(c), 32'd0);
      @(posedge clk); #2;
      convert(16'd12345, 20'h12345, 5'b00000, 1'b0);

      // Random values, random idle gaps and stray START pulses.
      for (int n = 0; n < 30; n++) begin
         v = 16'($urandom_range(0, 65535));
         if (n % 5 == 0) v = 16'($urandom_range(0, 120));
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
         convert(v, bcd_of(int'(v)), lz_of(int'(v)), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
